expr_result_fifo: RTL and testbench

//   Result buffer directly downstream of math_expression. Captures every cycle in which

---
 rtl/expr_pkg.sv | 21 ++
 rtl/expr_fifo_ram.sv | 26 ++
 rtl/expr_result_fifo.sv | 132 +++++++++++++
 tb/tb_expr_result_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared definitions for math_expression, its result buffer and their benches.
package expr_pkg;

  localparam int EXPR_W = 16;

  typedef struct packed {
    logic signed [EXPR_W-1:0] q;
    logic                     rmd;
  } expr_res_t;

  // (((a-b)*(1+3c))-4d)/2, truncating toward zero; rmd flags an odd numerator
  function automatic expr_res_t expr_golden(input int a, input int b, input int c, input int d);
    expr_res_t res;
    int        num;
    num     = ((a - b) * (1 + 3 * c)) - 4 * d;
    res.q   = EXPR_W'(num / 2);
    res.rmd = (num % 2) != 0;
    return res;
  endfunction

endpackage

// File: rtl/expr_fifo_ram.sv
// Storage array for expr_result_fifo: one clocked write port, one asynchronous read port.
module expr_fifo_ram #(
  parameter  int DW    = 17,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // Left unreset: occupancy is tracked by the controller, so stale words are never presented
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/expr_result_fifo.sv
// Result buffer behind math_expression: show-ahead FIFO with sticky overflow on drops.
// Defining EXPR_RES_STATS_EN adds running sum/count of accepted results.
module expr_result_fifo
  import expr_pkg::*;
#(
  parameter  int W     = EXPR_W,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic signed [W-1:0]   in_q,
  input  logic                  in_rmd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [W-1:0]   out_q,
  output logic                  out_rmd,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  overflow,
  input  logic                  clr_ovf
`ifdef EXPR_RES_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic signed [2*W-1:0] stat_sum,
  output logic [W-1:0]          stat_cnt
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, drop;
  logic [W:0]    rd_data;

  assign full      = (count_q == DEPTH_C);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // A fresh drop outranks a clear on the same edge
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  expr_fifo_ram #(
    .DW    (W + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({in_q, in_rmd}),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Empty FIFO shows zero rather than whatever the unreset array holds
  assign out_q    = out_valid ? $signed(rd_data[W:1]) : '0;
  assign out_rmd  = out_valid ? rd_data[0] : 1'b0;
  assign count    = count_q;
  assign overflow = ovf_q;

`ifdef EXPR_RES_STATS_EN
  logic signed [2*W-1:0] sum_q, sum_d;
  logic [W-1:0]          cnt_q, cnt_d;

  always_comb begin
    sum_d = stat_clr ? '0 : sum_q;
    cnt_d = stat_clr ? '0 : cnt_q;
    if (push) begin
      sum_d = sum_d + (2*W)'(in_q);
      if (cnt_d != '1) begin
        cnt_d = cnt_d + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  assign stat_sum = sum_q;
  assign stat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_expr_result_fifo.sv
// Randomized and directed bench for expr_result_fifo against a queue-based reference model.
module tb_expr_result_fifo;
  import expr_pkg::*;

  localparam int W     = EXPR_W;
  localparam int DEPTH = 4;

  logic                clk       = 1'b0;
  logic                reset     = 1'b0;
  logic                in_valid  = 1'b0;
  logic signed [W-1:0] in_q      = '0;
  logic                in_rmd    = 1'b0;
  logic                out_ready = 1'b0;
  logic                clr_ovf   = 1'b0;
  logic                out_valid, out_rmd, full, overflow;
  logic signed [W-1:0] out_q;
  logic [2:0]          count;
`ifdef EXPR_RES_STATS_EN
  logic                  stat_clr = 1'b0;
  logic signed [2*W-1:0] stat_sum;
  logic [W-1:0]          stat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [W:0]            mq[$];
  logic                  ovf_m;
  logic signed [2*W-1:0] sum_m;
  logic [W-1:0]          cnt_m;

  expr_result_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_q      (in_q),
    .in_rmd    (in_rmd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_rmd   (out_rmd),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
`ifdef EXPR_RES_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_sum  (stat_sum),
    .stat_cnt  (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] qv(input int v);
    return W'(v);
  endfunction

  task automatic compare_all(input string ph);
    logic [W:0] head;
    head = (mq.size() > 0) ? mq[0] : '0;
    check({ph, "_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    check({ph, "_count"}, 64'(count), 64'(mq.size()));
    check({ph, "_full"}, 64'(full), 64'(mq.size() == DEPTH));
    check({ph, "_ovf"}, 64'(overflow), 64'(ovf_m));
    check({ph, "_q"}, 64'($unsigned(out_q)), 64'(head[W:1]));
    check({ph, "_rmd"}, 64'(out_rmd), 64'(head[0]));
`ifdef EXPR_RES_STATS_EN
    check({ph, "_ssum"}, 64'($unsigned(stat_sum)), 64'($unsigned(sum_m)));
    check({ph, "_scnt"}, 64'(stat_cnt), 64'(cnt_m));
`endif
  endtask

  task automatic model_clear();
    mq.delete();
    ovf_m = 1'b0;
    sum_m = '0;
    cnt_m = '0;
  endtask

  // One clock edge: predict from the pre-edge model and inputs, then compare after the edge
  task automatic tick(input string ph);
    bit pop_m, push_m, drop_m;
    pop_m  = (mq.size() > 0) && out_ready;
    push_m = in_valid && ((mq.size() < DEPTH) || pop_m);
    drop_m = in_valid && !push_m;
    @(posedge clk);
    #1;
    if (pop_m) void'(mq.pop_front());
    if (push_m) mq.push_back({in_q, in_rmd});
    ovf_m = drop_m ? 1'b1 : (clr_ovf ? 1'b0 : ovf_m);
`ifdef EXPR_RES_STATS_EN
    if (stat_clr) begin
      sum_m = '0;
      cnt_m = '0;
    end
    if (push_m) begin
      sum_m = sum_m + in_q;
      if (cnt_m != '1) cnt_m = cnt_m + 1'b1;
    end
`endif
    compare_all(ph);
  endtask

  task automatic drive(input bit v, input int q, input bit r, input bit rdy, input string ph);
    in_valid  = v;
    in_q      = qv(q);
    in_rmd    = r;
    out_ready = rdy;
    tick(ph);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
`ifdef EXPR_RES_STATS_EN
    stat_clr  = 1'b0;
`endif
    #1;
    model_clear();
    compare_all("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    expr_res_t g[3];
    model_clear();
    g[0] = expr_golden(4, 6, 2, 1);
    g[1] = expr_golden(3, 3, 3, 3);
    g[2] = expr_golden(5, 3, 2, 1);

    // Reset and idle
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b0, 1'b0, "idle");

    // Three results through with a ready consumer
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, int'(g[i].q), g[i].rmd, 1'b1, "expr");
      check("expr_golden_q", 64'($unsigned(out_q)), 64'(qv(i == 0 ? -9 : (i == 1 ? -6 : 5))));
    end
    drive(1'b0, 0, 1'b0, 1'b1, "expr_drain");
    check("expr_empty", 64'(out_valid), 64'(0));

    // Overfill: six pushes into four entries
    do_reset();
    for (int i = 1; i <= 6; i++) drive(1'b1, i, 1'b0, 1'b0, "ovfl");
    check("ovfl_count", 64'(count), 64'(4));
    check("ovfl_full", 64'(full), 64'(1));
    check("ovfl_flag", 64'(overflow), 64'(1));
    for (int i = 1; i <= 4; i++) begin
      check("ovfl_drain_q", 64'($unsigned(out_q)), 64'(qv(i)));
      drive(1'b0, 0, 1'b0, 1'b1, "ovfl_drain");
    end
    check("ovfl_drain_empty", 64'(out_valid), 64'(0));

    // Full with simultaneous push and pop
    drive(1'b0, 0, 1'b0, 1'b0, "clr");
    clr_ovf = 1'b1;
    drive(1'b0, 0, 1'b0, 1'b0, "clr");
    clr_ovf = 1'b0;
    for (int i = 10; i <= 13; i++) drive(1'b1, i, 1'b1, 1'b0, "fill");
    drive(1'b1, 7, 1'b0, 1'b1, "pp");
    check("pp_count", 64'(count), 64'(4));
    check("pp_ovf", 64'(overflow), 64'(0));
    for (int i = 0; i < 4; i++) begin
      check("pp_order", 64'($unsigned(out_q)), 64'(qv(i == 3 ? 7 : 11 + i)));
      drive(1'b0, 0, 1'b0, 1'b1, "pp_drain");
    end

    // Clear colliding with a new drop
    for (int i = 0; i < 4; i++) drive(1'b1, 20 + i, 1'b0, 1'b0, "fill2");
    clr_ovf = 1'b1;
    drive(1'b1, 99, 1'b0, 1'b0, "clr_drop");
    clr_ovf = 1'b0;
    check("clr_drop_ovf", 64'(overflow), 64'(1));

    // Asynchronous reset between edges
    do_reset();
    drive(1'b1, 1, 1'b0, 1'b0, "pre_arst");
    drive(1'b1, 2, 1'b0, 1'b0, "pre_arst");
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'(0));
    check("arst_count", 64'(count), 64'(0));
    model_clear();
    #2;
    reset = 1'b1;
    drive(1'b1, -3, 1'b1, 1'b0, "post_arst");
    check("post_arst_q", 64'($unsigned(out_q)), 64'(qv(-3)));

`ifdef EXPR_RES_STATS_EN
    do_reset();
    drive(1'b1, 50, 1'b0, 1'b0, "st_pre");
    stat_clr = 1'b1;
    drive(1'b0, 0, 1'b0, 1'b0, "st_clr");
    stat_clr = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, int'(g[i].q), g[i].rmd, 1'b0, "st_push");
    drive(1'b1, 77, 1'b0, 1'b0, "st_drop");
    check("st_sum", 64'($unsigned(stat_sum)), 64'(32'(-10)));
    check("st_cnt", 64'(stat_cnt), 64'(3));
    stat_clr = 1'b1;
    drive(1'b1, 2, 1'b0, 1'b1, "st_clrpush");
    stat_clr = 1'b0;
    check("st_clr_sum", 64'($unsigned(stat_sum)), 64'(2));
    check("st_clr_cnt", 64'(stat_cnt), 64'(1));
`endif

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_q      = W'($urandom);
      in_rmd    = 1'($urandom);
      out_ready = ($urandom_range(0, 99) < 45);
      clr_ovf   = ($urandom_range(0, 19) == 0);
`ifdef EXPR_RES_STATS_EN
      stat_clr  = ($urandom_range(0, 29) == 0);
`endif
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
